sync_data_fifo: RTL and testbench
=================================

Name: sync_data_fifo

Overview:
- Parametrised synchronous FIFO; generalises the single-entry data buffer to DEPTH entries.
- Adds: empty flag, occupancy count, programmable almost-full threshold, first-word-fall-through read, simultaneous read/write when full, synchronous flush, sticky overflow/underflow flags.
- Sits between pipeline stages and bus-interface units wherever a multi-entry elastic buffer is needed.

Parameters:
- DataWidth, 64, width of each data entry in bits.
- Depth, 4, number of entries; any integer >= 2, not restricted to powers of two.
- AlmostFullThr, Depth-1, WAlmostFull asserts when Count >= AlmostFullThr; legal range 1..Depth.
- CntWidth (localparam), $clog2(Depth+1), width of Count.

Ports:
- Clk, input, 1, clock; all state updates on rising edge.
- Rst, input, 1, asynchronous active-low reset.
- Flush, input, 1, synchronous clear of contents and error flags.
- WData, input, DataWidth, write data.
- WInc, input, 1, write request.
- WFull, output, 1, FIFO holds Depth entries.
- WAlmostFull, output, 1, Count >= AlmostFullThr.
- RData, output, DataWidth, head entry (first-word-fall-through).
- RInc, input, 1, read request; pops the head.
- REmpty, output, 1, FIFO holds 0 entries.
- Count, output, CntWidth, current occupancy, 0..Depth.
- Overflow, output, 1, sticky; a write was dropped.
- Underflow, output, 1, sticky; a read hit an empty FIFO.

Behaviour:
- Reset (Rst=0, asynchronous): read pointer = 0, write pointer = 0, Count = 0, Overflow = 0, Underflow = 0. Outputs: REmpty=1, WFull=0, WAlmostFull=0, RData=0. Memory contents need not be reset.
- Storage: Depth x DataWidth register array. Read and write pointers each run 0..Depth-1 and wrap explicitly to 0 after Depth-1 (no power-of-two masking). Count is held as an explicit register.
- Write accepted (WAcc) = WInc & (!WFull | RInc).
  - A write while full is accepted only if a read happens in the same cycle.
- Read accepted (RAcc) = RInc & !REmpty.
- On a rising edge with Flush=0:
  - WAcc: mem[wptr] <= WData; wptr advances.
  - RAcc: rptr advances.
  - Count <= Count + WAcc - RAcc.
- Simultaneous read and write:
  - Not empty: Count unchanged, both pointers advance.
  - Empty: write accepted, read rejected (Underflow set), Count becomes 1. No bypass: write data appears on RData the following cycle.
- Dropped write (WInc & WFull & !RInc): Overflow <= 1; contents, pointers and Count unchanged.
- Read on empty (RInc & REmpty): Underflow <= 1; no state change.
- RData = mem[rptr] when !REmpty, else all-zero. Combinational from registered state; zero read latency.
- Write-to-read latency: 1 cycle. Data written at edge N is visible on RData after edge N when the FIFO was empty.
- Flush=1: pointers, Count, Overflow and Underflow all cleared at the edge. Flush overrides any WInc/RInc in that cycle; no data is accepted.
- Flag derivation from registered Count only: REmpty = (Count==0), WFull = (Count==Depth), WAlmostFull = (Count>=AlmostFullThr). Flags are glitch-free relative to Clk.
- Reset asserted mid-operation: immediate clear per the reset rule; no partial writes.

Decomposition:
- No shared package required. Depth-derived widths are localparams in the module.
- One natural sub-module: fifo_wrap_ptr.
  - Parameter Depth.
  - Ports: Clk, Rst, Clr, Inc, Ptr.
  - Increments modulo Depth; Clr takes priority.
  - Instantiated twice, once for read and once for write.

Test Plan:
All scenarios use DataWidth=8, Depth=4, AlmostFullThr=3.
1. Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> Count 1,2,3,4. WAlmostFull rises with Count=3; WFull=1 after the 4th write. RData=0x11 throughout.
2. From full, pulse WInc alone with 0x55 -> Overflow=1, Count stays 4. Then read 4 times -> RData sequence 0x11,0x22,0x33,0x44, REmpty=1 afterwards, RData=0.
3. From full, WInc+RInc with 0x66 in the same cycle -> Count stays 4, Overflow stays 0, head becomes 0x22. Draining yields 0x22,0x33,0x44,0x66.
4. Pointer wrap: 10 cycles of interleaved write/read with data 0x01..0x0A -> reads return 0x01..0x0A in order, Count never exceeds 2, no flags set.
5. Empty FIFO, RInc+WInc with 0x77 -> Underflow=1, Count=1, next cycle RData=0x77. Then Flush with WInc=1 -> Count=0, REmpty=1, Overflow=0, Underflow=0.
6. Write 2 entries, assert Rst low between clock edges -> REmpty=1 and Count=0 immediately, before the next edge.

Source files
------------

// File: rtl/sync_data_fifo_pkg.sv
// Shared types and helpers for the synchronous data FIFO.
package sync_data_fifo_pkg;

  // Per-cycle operation seen by the occupancy counter.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Modulo increment for indices that need not be powers of two.
  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Index register counting 0..Depth-1 with explicit wrap; Clr wins over Inc.
module fifo_wrap_ptr
  import sync_data_fifo_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrWidth = $clog2(Depth)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Clr,
  input  logic                Inc,
  output logic [PtrWidth-1:0] Ptr
);

  logic [PtrWidth-1:0] ptr_q;
  logic [PtrWidth-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (Clr) begin
      ptr_d = '0;
    end else if (Inc) begin
      ptr_d = PtrWidth'(wrap_next(32'(ptr_q), Depth));
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign Ptr = ptr_q;

endmodule

// File: rtl/sync_data_fifo.sv
// Parametrised first-word-fall-through FIFO with occupancy, almost-full and sticky error flags.
module sync_data_fifo
  import sync_data_fifo_pkg::*;
#(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned Depth         = 4,
  parameter int unsigned AlmostFullThr = Depth - 1,
  localparam int unsigned CntWidth     = $clog2(Depth + 1)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Flush,
  input  logic [DataWidth-1:0] WData,
  input  logic                 WInc,
  output logic                 WFull,
  output logic                 WAlmostFull,
  output logic [DataWidth-1:0] RData,
  input  logic                 RInc,
  output logic                 REmpty,
  output logic [CntWidth-1:0]  Count,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  rptr;
  logic [PtrWidth-1:0]  wptr;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 empty, full;
  logic                 w_acc, r_acc;
  fifo_op_e             op;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntWidth'(Depth));

  // A write into a full FIFO is only taken when the head is popped the same cycle.
  assign w_acc = WInc & (~full | RInc) & ~Flush;
  assign r_acc = RInc & ~empty & ~Flush;
  assign op    = fifo_op_e'({r_acc, w_acc});

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (Flush) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: count_d = count_q + CntWidth'(1);
        OP_POP:  count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
      if (WInc && full && !RInc) ovf_d = 1'b1;
      if (RInc && empty)         unf_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; RData is masked to zero while empty.
  always_ff @(posedge Clk) begin
    if (w_acc) begin
      mem_q[wptr] <= WData;
    end
  end

  fifo_wrap_ptr #(.Depth(Depth)) u_wptr (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (Flush),
    .Inc (w_acc),
    .Ptr (wptr)
  );

  fifo_wrap_ptr #(.Depth(Depth)) u_rptr (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (Flush),
    .Inc (r_acc),
    .Ptr (rptr)
  );

  assign RData       = empty ? '0 : mem_q[rptr];
  assign REmpty      = empty;
  assign WFull       = full;
  assign WAlmostFull = (count_q >= CntWidth'(AlmostFullThr));
  assign Count       = count_q;
  assign Overflow    = ovf_q;
  assign Underflow   = unf_q;

endmodule

// File: tb/tb_sync_data_fifo.sv
// Directed and random checks of sync_data_fifo against a queue-based reference model.
module tb_sync_data_fifo;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 4;
  localparam int unsigned AFT = 3;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] wdata;
  logic          winc;
  logic          rinc;
  logic          wfull;
  logic          wafull;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic [2:0]    count;
  logic          ovf;
  logic          unf;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_unf;

  sync_data_fifo #(.DataWidth(DW), .Depth(DEP), .AlmostFullThr(AFT)) dut (
    .Clk         (clk),
    .Rst         (rst_n),
    .Flush       (flush),
    .WData       (wdata),
    .WInc        (winc),
    .WFull       (wfull),
    .WAlmostFull (wafull),
    .RData       (rdata),
    .RInc        (rinc),
    .REmpty      (rempty),
    .Count       (count),
    .Overflow    (ovf),
    .Underflow   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] exp_rd;
    exp_rd = (mq.size() == 0) ? 64'h0 : 64'(mq[0]);
    chk({tag, ".count"},  64'(count),  64'(mq.size()));
    chk({tag, ".empty"},  64'(rempty), 64'(mq.size() == 0));
    chk({tag, ".full"},   64'(wfull),  64'(mq.size() == DEP));
    chk({tag, ".afull"},  64'(wafull), 64'(mq.size() >= AFT));
    chk({tag, ".rdata"},  64'(rdata),  exp_rd);
    chk({tag, ".ovf"},    64'(ovf),    64'(m_ovf));
    chk({tag, ".unf"},    64'(unf),    64'(m_unf));
  endtask

  // Reference: a read pops the head if anything is there; a write lands if room
  // exists or a read is frees a slot in the same cycle.
  task automatic model_update(input bit w, input bit r, input logic [DW-1:0] d, input bit f);
    bit can_w;
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    can_w = w && ((mq.size() < DEP) || r);
    if (w && mq.size() == DEP && !r) m_ovf = 1'b1;
    if (r && mq.size() == 0) m_unf = 1'b1;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (can_w) mq.push_back(d);
  endtask

  task automatic step(input string tag, input bit w, input bit r, input logic [DW-1:0] d,
                      input bit f);
    @(negedge clk);
    winc  = w;
    rinc  = r;
    wdata = d;
    flush = f;
    @(posedge clk);
    model_update(w, r, d, f);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    winc  = 1'b0;
    rinc  = 1'b0;
    flush = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: fill
    step("s1_w11", 1, 0, 8'h11, 0);
    step("s1_w22", 1, 0, 8'h22, 0);
    step("s1_w33", 1, 0, 8'h33, 0);
    chk("s1_afull_at3", 64'(wafull), 64'h1);
    step("s1_w44", 1, 0, 8'h44, 0);
    chk("s1_full", 64'(wfull), 64'h1);
    chk("s1_head", 64'(rdata), 64'h11);

    // Scenario 2: overflow then drain
    step("s2_ovf", 1, 0, 8'h55, 0);
    chk("s2_ovf_set", 64'(ovf), 64'h1);
    for (int i = 0; i < 4; i++) step("s2_rd", 0, 1, 8'h00, 0);
    chk("s2_rdata_zero", 64'(rdata), 64'h0);

    // Scenario 3: simultaneous read/write while full
    step("s3_flush", 0, 0, 8'h00, 1);
    step("s3_w11", 1, 0, 8'h11, 0);
    step("s3_w22", 1, 0, 8'h22, 0);
    step("s3_w33", 1, 0, 8'h33, 0);
    step("s3_w44", 1, 0, 8'h44, 0);
    step("s3_rw66", 1, 1, 8'h66, 0);
    chk("s3_head22", 64'(rdata), 64'h22);
    chk("s3_no_ovf", 64'(ovf), 64'h0);
    for (int i = 0; i < 4; i++) step("s3_drain", 0, 1, 8'h00, 0);

    // Scenario 4: pointer wrap with interleaved traffic
    step("s4_w01", 1, 0, 8'h01, 0);
    for (int i = 2; i <= 10; i++) begin
      step("s4_rw", 1, 1, DW'(i), 0);
      chk("s4_cnt_le2", 64'(count <= 3'd2), 64'h1);
    end
    chk("s4_head0a", 64'(rdata), 64'h0a);
    step("s4_rd", 0, 1, 8'h00, 0);

    // Scenario 5: underflow on empty read+write, then flush
    step("s5_rw77", 1, 1, 8'h77, 0);
    chk("s5_unf", 64'(unf), 64'h1);
    chk("s5_rd77", 64'(rdata), 64'h77);
    step("s5_flush", 1, 0, 8'h99, 1);
    chk("s5_flush_cnt", 64'(count), 64'h0);

    // Scenario 6: asynchronous reset between edges
    step("s6_wa", 1, 0, 8'hA1, 0);
    step("s6_wb", 1, 0, 8'hB2, 0);
    idle();
    #2;
    rst_n = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    chk("s6_empty_async", 64'(rempty), 64'h1);
    chk("s6_count_async", 64'(count), 64'h0);
    check_all("s6_async");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50),
           DW'($urandom),
           ($urandom_range(0, 63) == 0));
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
